// File: rtl/isa_pkg.sv
// Instruction-set constants and the fetch-stage state type shared by the
// fetch stage, the decoder and the register file.
package isa_pkg;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNC_HI  = 5;
    localparam int FUNC_LO  = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ITYPE = 6'b111111;

    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLL = 6'b000000;
    localparam logic [5:0] FUNC_SRL = 6'b000010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle between the fetch stage (slave) and whoever controls it and
// consumes its instructions (master).
interface instr_fetch_if #(parameter int ADDR_W = 8);
    import isa_pkg::*;

    // No valid/ready pair: start is a one-cycle request honoured in IDLE/DONE,
    // stall freezes the stage, and valid marks instr as a fetched word.
    logic              start;
    logic              stall;
    logic [ADDR_W:0]   prog_len;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;

    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        func;
    logic [15:0]       imm;
    logic [ADDR_W-1:0] instr_pc;
    logic              valid;
    logic              busy;
    logic              done;
    fetch_state_e      dbg_state;

    modport master (
        output start, stall, prog_len, load_en, load_addr, load_data,
        input  instr, opcode, rs, rt, rd, shamt, func, imm,
        input  instr_pc, valid, busy, done, dbg_state
    );

    modport slave (
        input  start, stall, prog_len, load_en, load_addr, load_data,
        output instr, opcode, rs, rt, rd, shamt, func, imm,
        output instr_pc, valid, busy, done, dbg_state
    );

endinterface

// File: rtl/imem_sync.sv
// Synchronous instruction RAM: one write port, one registered read port.
// Only the read register is cleared by reset; the array keeps its contents.
module imem_sync #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: walks a PC over the instruction RAM and presents one
// registered instruction per unstalled cycle, sliced into MIPS fields.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    instr_fetch_if.slave bus
);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [ADDR_W:0]   r_len_q;
    logic              r_valid;

    logic              w_we;
    logic              w_re;
    logic              w_last;
    logic [DATA_W-1:0] w_instr;

    // Loads are locked out while fetching so a write never races a read.
    assign w_we   = bus.load_en && (r_state != RUN) && !rst;
    assign w_re   = (r_state == RUN) && !bus.stall;
    assign w_last = ({1'b0, r_fetch_pc} == (r_len_q - 1'b1));

    imem_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (bus.load_addr),
        .i_wdata (bus.load_data),
        .i_re    (w_re),
        .i_raddr (r_fetch_pc),
        .o_rdata (w_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= '0;
            r_instr_pc <= '0;
            r_len_q    <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (!bus.stall) begin
                        r_instr_pc <= r_fetch_pc;
                        r_valid    <= 1'b1;
                        r_fetch_pc <= r_fetch_pc + 1'b1;
                        if (w_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE share the start path; a restart wins over
                    // the one-cycle clear of the final valid.
                    if (bus.start) begin
                        r_len_q    <= bus.prog_len;
                        r_fetch_pc <= '0;
                        r_valid    <= 1'b0;
                        r_state    <= (bus.prog_len != '0) ? RUN : DONE;
                    end else if (!bus.stall) begin
                        r_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.instr     = w_instr[31:0];
    assign bus.opcode    = w_instr[OPC_HI:OPC_LO];
    assign bus.rs        = w_instr[RS_HI:RS_LO];
    assign bus.rt        = w_instr[RT_HI:RT_LO];
    assign bus.rd        = w_instr[RD_HI:RD_LO];
    assign bus.shamt     = w_instr[SHAMT_HI:SHAMT_LO];
    assign bus.func      = w_instr[FUNC_HI:FUNC_LO];
    assign bus.imm       = w_instr[IMM_HI:IMM_LO];
    assign bus.instr_pc  = r_instr_pc;
    assign bus.valid     = r_valid;
    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.dbg_state = r_state;

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the single-cycle control decoder.
- Holds a word-addressed instruction memory, loaded through a write port while the stage is not running.
- Steps a fetch PC through that memory and registers one 32-bit instruction per cycle.
- Presents the registered instruction plus its MIPS-style fields (opcode, func, rs, rt, rd, shamt, imm) with a valid flag, for the decoder and register file.

Parameters:
ADDR_W, 8, width of word address / PC; memory depth = 2**ADDR_W words
DATA_W, 32, instruction width (fixed at 32; field slicing assumes it)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: begin fetching from address 0
stall  in  1  freeze fetch PC and instruction register
prog_len  in  ADDR_W+1  number of instructions to fetch (0..2**ADDR_W), sampled on accepted start
load_en  in  1  memory write enable
load_addr  in  ADDR_W  memory write address
load_data  in  32  memory write data
instr  out  32  registered instruction
opcode  out  6  instr[31:26]
rs  out  5  instr[25:21]
rt  out  5  instr[20:16]
rd  out  5  instr[15:11]
shamt  out  5  instr[10:6]
func  out  6  instr[5:0]
imm  out  16  instr[15:0]
instr_pc  out  ADDR_W  word address of instr
valid  out  1  instr holds a fetched instruction
busy  out  1  state == RUN
done  out  1  state == DONE

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - state=IDLE; fetch_pc=0; instr=0; instr_pc=0; valid=0; len_q=0.
  - Memory contents are not reset.
  - rst dominates start, stall and load_en, including mid-RUN: the next cycle is IDLE with valid=0.
- Field outputs are pure combinational slices of instr; no extra latency.
- Memory write:
  - On an edge with load_en=1 and state != RUN: mem[load_addr] <= load_data.
  - load_en in RUN is ignored (no write).
- Memory read: synchronous; fetch latency 1 cycle from PC to instr.
- States:
  - IDLE: on start=1 -> capture len_q=prog_len, fetch_pc=0. Next state RUN if prog_len != 0, else DONE. valid stays 0.
  - RUN, stall=0:
    - instr <= mem[fetch_pc]; instr_pc <= fetch_pc; valid <= 1; fetch_pc <= fetch_pc+1 (wraps mod 2**ADDR_W).
    - If fetch_pc == len_q-1, next state DONE.
  - RUN, stall=1: fetch_pc, instr, instr_pc, valid and state all hold. start is ignored in RUN.
  - DONE, stall=0: valid <= 0 on the first edge, so the last instruction is valid for exactly one unstalled cycle. instr and instr_pc hold their last values.
  - DONE, stall=1: valid and instr hold.
  - DONE, start=1: behaves as IDLE+start (restart from 0 with a newly sampled prog_len). A start on the same edge as the valid<=0 clear takes precedence: valid <= 0, fetch_pc <= 0.
- prog_len = 2**ADDR_W fetches the whole memory; fetch_pc wraps to 0 as DONE is entered.
- Same-address load and fetch cannot collide (load is blocked in RUN).
- Unstalled throughput: exactly one instruction per cycle. First valid appears 2 edges after the start edge.

Decomposition:
- Shared package (isa_pkg): field bit-position constants (OPC_HI/LO, RS, RT, RD, SHAMT, FUNC, IMM); opcode constants OPC_RTYPE=6'b000000, OPC_ITYPE=6'b111111; func constants ADD=100000, SUB=100010, AND=100100, OR=100101, SLL=000000, SRL=000010; fetch state enum {IDLE, RUN, DONE}.
- One sub-module: imem_sync, a single-port-write / single-port-read synchronous RAM, 2**ADDR_W x 32, used as the instruction store.

Test Plan:
- Reset/idle: rst=1 for 2 cycles then idle 5 cycles -> valid=0, instr=0, instr_pc=0, busy=0, done=0 throughout.
- Straight run:
  - Stimulus: load mem[0..3] = 0x00221820 (add), 0x00221822 (sub), 0xFC220005 (I-type), 0x00021080 (sll); prog_len=4; pulse start.
  - Required: valid=1 for exactly 4 consecutive cycles starting 2 edges after start, instr_pc=0,1,2,3; at instr=0x00221820, opcode=0, rs=1, rt=2, rd=3, func=0x20; done=1 after the last fetch.
- Stall: same program; assert stall for 3 cycles while instr_pc=1 -> instr stays 0x00221822 and valid=1 for those cycles; sequence resumes at 2 with no instruction skipped or repeated.
- Edge lengths:
  - prog_len=0 + start -> DONE next cycle, valid never rises.
  - prog_len=256 (ADDR_W=8) -> 256 valid cycles, instr_pc 0..255, then done.
- Load protection: during RUN drive load_en=1, load_addr=2, load_data=0xDEADBEEF -> a later restart still fetches 0xFC220005 at address 2.
- Mid-run reset and restart:
  - rst at instr_pc=1 -> next cycle state IDLE, valid=0.
  - start from DONE with prog_len=2 -> re-fetches addresses 0,1 only.
